// File: rtl/pio_sample_arbiter.sv
// pio_sample_arbiter: round-robin share of one 32-bit HPS-readable PIO input among NUM_CH sample producers.
// Latency: grant is combinational in IDLE, the tagged word appears on pio_word one clk_clk after the transfer,
//          and an HPS ack toggle releases the word on the third clk_clk edge after the toggle.
// Backpressure: ch_ready stays low while a word waits for its ack (busy=1); producers hold ch_valid/ch_data.
//
// Ports:
//   clk_clk, reset_reset   clock, asynchronous active-high reset
//   ch_valid/ch_data       per-channel sample requests, channel i data at [i*DATA_W +: DATA_W]
//   ch_ready               one-hot accept, only in IDLE
//   hps_ack_toggle         asynchronous ack from the HPS output PIO; every edge acks the current word
//   pio_word               {valid, seq[2:0], channel[3:0], data[23:0]} to pio_0_external_connection_export
//   busy                   high while waiting for the ack
//   timeout_cnt            saturating count of abandoned words
// Optional feature macro: PIO_TIMEOUT_EN (abandon a word after TIMEOUT_CYC unacked cycles).
module pio_sample_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 5000000
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_ready,
  input  logic                     hps_ack_toggle,
  output logic [31:0]              pio_word,
  output logic                     busy,
  output logic [15:0]              timeout_cnt
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        seq_q, seq_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [31:0]       pio_word_q, pio_word_d;
  logic              s1_q, s1_d;
  logic              s2_q, s2_d;
  logic              ack_prev_q, ack_prev_d;

  logic              ack_edge;
  logic              expire;
  logic              found;
  int                grant_off;
  int                grant_pos;
  logic [3:0]        grant_idx;
  logic [PTR_W-1:0]  grant_next;
  logic [NUM_CH-1:0] grant_oh;
  logic [NUM_CH-1:0] valid_rot;
  logic [23:0]       data_ext;

`ifdef PIO_TIMEOUT_EN
  localparam int WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [15:0]       timeout_cnt_q, timeout_cnt_d;

  assign expire      = (wait_cnt_q == WAIT_W'(TIMEOUT_CYC - 1));
  assign timeout_cnt = timeout_cnt_q;
`else
  assign expire      = 1'b0;
  assign timeout_cnt = '0;
`endif

  // Rotate the request vector so that bit 0 is the channel at rr_ptr; the
  // lowest set bit of the rotated vector is then the round-robin winner.
  always_comb begin
    valid_rot = NUM_CH'({ch_valid, ch_valid} >> rr_ptr_q);
    found     = 1'b0;
    grant_off = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && valid_rot[k]) begin
        found     = 1'b1;
        grant_off = k;
      end
    end
    grant_pos = int'(rr_ptr_q) + grant_off;
    if (grant_pos >= NUM_CH) begin
      grant_pos = grant_pos - NUM_CH;
    end
    grant_idx  = 4'(grant_pos);
    grant_next = (grant_pos + 1 >= NUM_CH) ? '0 : PTR_W'(grant_pos + 1);
    grant_oh   = found ? (NUM_CH'(1) << grant_pos) : '0;
    data_ext   = '0;
    data_ext[DATA_W-1:0] = DATA_W'(ch_data >> (grant_pos * DATA_W));
  end

  assign ack_edge = s2_q ^ ack_prev_q;

  // Reset gates ch_ready directly so no producer sees an accept while the
  // block is held in reset.
  assign ch_ready = (state_q == IDLE && !reset_reset) ? grant_oh : '0;
  assign busy     = (state_q == WAIT_ACK);
  assign pio_word = pio_word_q;

  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    rr_ptr_d   = rr_ptr_q;
    pio_word_d = pio_word_q;
    // Synchronizer and edge history run in every state, so an ack edge that
    // arrives in IDLE is consumed there and never carried into the next word.
    s1_d       = hps_ack_toggle;
    s2_d       = s1_q;
    ack_prev_d = s2_q;
`ifdef PIO_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (found) begin
          pio_word_d = {1'b1, seq_q, grant_idx, data_ext};
          rr_ptr_d   = grant_next;
          state_d    = WAIT_ACK;
`ifdef PIO_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end
      end
      WAIT_ACK: begin
`ifdef PIO_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q + 1'b1;
        // An ack in the expiry cycle is a normal ack and is not counted.
        if (!ack_edge && expire && timeout_cnt_q != 16'hFFFF) begin
          timeout_cnt_d = timeout_cnt_q + 16'd1;
        end
`endif
        if (ack_edge || expire) begin
          pio_word_d = {1'b0, pio_word_q[30:0]};
          seq_d      = seq_q + 3'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q       <= IDLE;
      seq_q         <= '0;
      rr_ptr_q      <= '0;
      pio_word_q    <= '0;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      ack_prev_q    <= 1'b0;
`ifdef PIO_TIMEOUT_EN
      wait_cnt_q    <= '0;
      timeout_cnt_q <= '0;
`endif
    end else begin
      state_q       <= state_d;
      seq_q         <= seq_d;
      rr_ptr_q      <= rr_ptr_d;
      pio_word_q    <= pio_word_d;
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      ack_prev_q    <= ack_prev_d;
`ifdef PIO_TIMEOUT_EN
      wait_cnt_q    <= wait_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_pio_sample_arbiter.sv
// tb_pio_sample_arbiter: randomized and directed bench for pio_sample_arbiter with a behavioural model.
// Latency: checks one-clock word latency and three-clock ack release from the toggle.
// Backpressure: producers hold ch_valid while the arbiter waits for the HPS ack.
module tb_pio_sample_arbiter;

  localparam int NUM_CH      = 4;
  localparam int DATA_W      = 16;
  localparam int TIMEOUT_CYC = 8;

  logic                     clk_clk = 1'b0;
  logic                     reset_reset;
  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_ready;
  logic                     hps_ack_toggle;
  logic [31:0]              pio_word;
  logic                     busy;
  logic [15:0]              timeout_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int          m_seq;
  int          m_ptr;
  int          m_tmo;
  logic [31:0] m_last;

  pio_sample_arbiter #(
    .NUM_CH(NUM_CH),
    .DATA_W(DATA_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk_clk(clk_clk),
    .reset_reset(reset_reset),
    .ch_valid(ch_valid),
    .ch_data(ch_data),
    .ch_ready(ch_ready),
    .hps_ack_toggle(hps_ack_toggle),
    .pio_word(pio_word),
    .busy(busy),
    .timeout_cnt(timeout_cnt)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  // Round-robin winner: first valid channel looking from the pointer onward.
  function automatic int model_grant(input logic [NUM_CH-1:0] v, input int ptr);
    for (int k = 0; k < NUM_CH; k++) begin
      if (v[(ptr + k) % NUM_CH]) return (ptr + k) % NUM_CH;
    end
    return -1;
  endfunction

  function automatic logic [NUM_CH-1:0] onehot(input int ch);
    logic [NUM_CH-1:0] r;
    r = '0;
    if (ch >= 0) r[ch] = 1'b1;
    return r;
  endfunction

  function automatic logic [15:0] chan_data(input int ch);
    return ch_data[ch*DATA_W +: DATA_W];
  endfunction

  task automatic model_accept(input int ch);
    m_last = 32'h8000_0000 + 32'((m_seq % 8) * (1 << 28)) + 32'(ch * (1 << 24)) + 32'(chan_data(ch));
    m_ptr  = (ch + 1) % NUM_CH;
  endtask

  task automatic model_release();
    m_last[31] = 1'b0;
    m_seq      = (m_seq + 1) % 8;
  endtask

  task automatic model_reset();
    m_seq  = 0;
    m_ptr  = 0;
    m_tmo  = 0;
    m_last = '0;
  endtask

  task automatic test_reset();
    reset_reset    = 1'b1;
    ch_valid       = '0;
    ch_data        = '0;
    hps_ack_toggle = 1'b0;
    model_reset();
    tick();
    tick();
    n_tests++; if (pio_word !== 32'h0) begin n_fail++; $display("FAIL reset_pio_word: got %h want 0", pio_word); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (timeout_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_timeout_cnt: got %h want 0", timeout_cnt); end
    ch_valid = 4'b1111;
    #1;
    n_tests++; if (ch_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ch_ready: got %b want 0000", ch_ready); end
    ch_valid = '0;
    tick();
    reset_reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    ch_valid = 4'b0001;
    ch_data[15:0] = 16'hBEEF;
    #1;
    n_tests++; if (ch_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b want 0001", ch_ready); end
    tick();
    model_accept(0);
    ch_valid = '0;
    n_tests++; if (pio_word !== 32'h8000BEEF || pio_word !== m_last) begin n_fail++; $display("FAIL single_word: got %h want 8000beef", pio_word); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
  endtask

  task automatic test_ack_next();
    hps_ack_toggle = ~hps_ack_toggle;
    tick();
    tick();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ack_early_busy: got %b want 1", busy); end
    tick();
    model_release();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ack_busy: got %b want 0", busy); end
    n_tests++; if (pio_word !== m_last) begin n_fail++; $display("FAIL ack_word: got %h want %h", pio_word, m_last); end
    ch_valid = 4'b1000;
    ch_data[63:48] = 16'h1234;
    #1;
    n_tests++; if (ch_ready !== 4'b1000) begin n_fail++; $display("FAIL ch3_ready: got %b want 1000", ch_ready); end
    tick();
    model_accept(3);
    ch_valid = '0;
    n_tests++; if (pio_word !== 32'h93001234) begin n_fail++; $display("FAIL ch3_word: got %h want 93001234", pio_word); end
    hps_ack_toggle = ~hps_ack_toggle;
    repeat (3) tick();
    model_release();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ch3_release: got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    int exp_ch;
    int order[$];
    ch_valid = 4'b1111;
    for (int w = 0; w < 9; w++) begin
      ch_data = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      #1;
      exp_ch = model_grant(ch_valid, m_ptr);
      order.push_back(exp_ch);
      n_tests++; if (ch_ready !== onehot(exp_ch)) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b want %b", w, ch_ready, onehot(exp_ch)); end
      tick();
      model_accept(exp_ch);
      n_tests++; if (pio_word !== m_last) begin n_fail++; $display("FAIL rr_word[%0d]: got %h want %h", w, pio_word, m_last); end
      n_tests++; if (ch_ready !== 4'b0000) begin n_fail++; $display("FAIL rr_wait_ready[%0d]: got %b want 0000", w, ch_ready); end
      hps_ack_toggle = ~hps_ack_toggle;
      repeat (3) tick();
      model_release();
      n_tests++; if (busy !== 1'b0 || pio_word !== m_last) begin n_fail++; $display("FAIL rr_release[%0d]: got busy=%b word=%h want busy=0 word=%h", w, busy, pio_word, m_last); end
    end
    n_tests++; if (order[4] !== order[0] || order[1] !== (order[0] + 1) % 4) begin n_fail++; $display("FAIL rr_order: got %0d,%0d,%0d want wrap to first", order[0], order[1], order[4]); end
    ch_valid = '0;
  endtask

  task automatic test_idle_ack();
    hps_ack_toggle = ~hps_ack_toggle;
    repeat (5) tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_ack_busy: got %b want 0", busy); end
    ch_valid = 4'b0100;
    ch_data[47:32] = 16'($urandom);
    tick();
    model_accept(2);
    ch_valid = '0;
    n_tests++; if (pio_word !== m_last) begin n_fail++; $display("FAIL idle_ack_word: got %h want %h", pio_word, m_last); end
    repeat (4) tick();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL idle_ack_no_auto: got %b want 1", busy); end
    hps_ack_toggle = ~hps_ack_toggle;
    repeat (3) tick();
    model_release();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_ack_release: got %b want 0", busy); end
  endtask

  task automatic test_async_reset();
    ch_valid = 4'b0010;
    tick();
    model_accept(1);
    ch_valid = 4'b1111;
    #2;
    reset_reset = 1'b1;
    #1;
    model_reset();
    n_tests++; if (pio_word !== 32'h0) begin n_fail++; $display("FAIL arst_word: got %h want 0", pio_word); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b want 0", busy); end
    n_tests++; if (ch_ready !== 4'b0000) begin n_fail++; $display("FAIL arst_ready: got %b want 0000", ch_ready); end
    hps_ack_toggle = 1'b0;
    tick();
    tick();
    reset_reset = 1'b0;
    #1;
    n_tests++; if (ch_ready !== onehot(model_grant(ch_valid, m_ptr))) begin n_fail++; $display("FAIL arst_first_grant: got %b want 0001", ch_ready); end
    tick();
    model_accept(0);
    ch_valid = '0;
    n_tests++; if (pio_word !== m_last) begin n_fail++; $display("FAIL arst_word_after: got %h want %h", pio_word, m_last); end
    hps_ack_toggle = ~hps_ack_toggle;
    repeat (3) tick();
    model_release();
  endtask

  task automatic test_timeout();
    int n;
    ch_valid = 4'b0010;
    ch_data[31:16] = 16'($urandom);
    tick();
    model_accept(1);
    ch_valid = '0;
    n = 0;
`ifdef PIO_TIMEOUT_EN
    while (busy === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    model_release();
    m_tmo++;
    n_tests++; if (n !== TIMEOUT_CYC) begin n_fail++; $display("FAIL tmo_cycles: got %0d want %0d", n, TIMEOUT_CYC); end
    n_tests++; if (timeout_cnt !== 16'(m_tmo)) begin n_fail++; $display("FAIL tmo_count: got %0d want %0d", timeout_cnt, m_tmo); end
    n_tests++; if (pio_word !== m_last) begin n_fail++; $display("FAIL tmo_word: got %h want %h", pio_word, m_last); end
    ch_valid = 4'b0100;
    tick();
    model_accept(2);
    ch_valid = '0;
    n_tests++; if (pio_word !== m_last) begin n_fail++; $display("FAIL tmo_next_seq: got %h want %h", pio_word, m_last); end
`else
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (busy !== 1'b1) n++;
    end
    n_tests++; if (n !== 0) begin n_fail++; $display("FAIL no_tmo_busy: got %0d idle cycles want 0", n); end
    n_tests++; if (timeout_cnt !== 16'h0) begin n_fail++; $display("FAIL no_tmo_count: got %0d want 0", timeout_cnt); end
`endif
    hps_ack_toggle = ~hps_ack_toggle;
    repeat (3) tick();
    model_release();
    n_tests++; if (busy !== 1'b0 || pio_word !== m_last) begin n_fail++; $display("FAIL tmo_final: got busy=%b word=%h want 0 %h", busy, pio_word, m_last); end
  endtask

  task automatic test_random();
    int exp_ch;
    for (int it = 0; it < 40; it++) begin
      ch_valid = NUM_CH'($urandom);
      ch_data  = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      #1;
      exp_ch = model_grant(ch_valid, m_ptr);
      n_tests++; if (ch_ready !== onehot(exp_ch)) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b", it, ch_ready, onehot(exp_ch)); end
      tick();
      if (exp_ch < 0) begin
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rnd_idle[%0d]: got %b want 0", it, busy); end
      end else begin
        model_accept(exp_ch);
        n_tests++; if (pio_word !== m_last || busy !== 1'b1) begin n_fail++; $display("FAIL rnd_word[%0d]: got %h busy=%b want %h busy=1", it, pio_word, busy, m_last); end
        repeat ($urandom_range(0, 3)) tick();
        hps_ack_toggle = ~hps_ack_toggle;
        repeat (3) tick();
        model_release();
        n_tests++; if (pio_word !== m_last || busy !== 1'b0) begin n_fail++; $display("FAIL rnd_release[%0d]: got %h busy=%b want %h busy=0", it, pio_word, busy, m_last); end
      end
    end
    ch_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_ack_next();
    test_round_robin();
    test_idle_ack();
    test_async_reset();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
